// File: rtl/proc_block_buffer_pkg.sv
// Shared types and constants for the processing-memory block buffer stage.
// Transaction-type encoding matches the upstream write router.
package proc_block_buffer_pkg;

    localparam int unsigned PAWUSER_WIDTH = 1;

    localparam logic [PAWUSER_WIDTH-1:0] REGULAR = 1'b0;
    localparam logic [PAWUSER_WIDTH-1:0] BLOCK   = 1'b1;

    typedef logic [1:0] proc_state_t;

    localparam proc_state_t P_IDLE = 2'd0;
    localparam proc_state_t P_FILL = 2'd1;
    localparam proc_state_t P_DROP = 2'd2;

    function automatic logic is_block(input logic [PAWUSER_WIDTH-1:0] user);
        return user == BLOCK;
    endfunction

endpackage

// File: rtl/proc_block_buffer_if.sv
// Routed AW/W write stream in, framed drain stream out.
// The slave modport is the buffer side, the master modport drives it.
interface proc_block_buffer_if
    import proc_block_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                     s_awvalid;
    logic                     s_awready;
    logic [PAWUSER_WIDTH-1:0] s_awuser;
    logic                     s_wvalid;
    logic                     s_wready;
    logic [DATA_WIDTH-1:0]    s_wdata;
    logic                     s_wlast;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_WIDTH-1:0]    m_data;
    logic                     m_last;

    modport slave (
        input  s_awvalid, s_awuser, s_wvalid, s_wdata, s_wlast, m_ready,
        output s_awready, s_wready, m_valid, m_data, m_last
    );

    modport master (
        output s_awvalid, s_awuser, s_wvalid, s_wdata, s_wlast, m_ready,
        input  s_awready, s_wready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/proc_block_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO; exports current and next occupancy.
// Read data is the rd_ptr entry, so a write shows on the output one cycle later.
module proc_block_buffer_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [$clog2(DEPTH+1)-1:0] o_count_next_c
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_wr_en && (r_count != CNT_W'(DEPTH));
    assign w_rd = i_rd_en && (r_count != '0);

    // Simultaneous read and write leaves occupancy unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    assign o_rd_data      = r_mem[r_rd_ptr];
    assign o_count        = r_count;
    assign o_count_next_c = w_count_next;

endmodule

// File: rtl/proc_block_buffer.sv
// Stores BLOCK-type write bursts for the processing consumer, discards REGULAR bursts,
// and produces the proc_full / block_fin feedback consumed by the write router.
module proc_block_buffer
    import proc_block_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned PEND_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    proc_block_buffer_if.slave    bus,
    output logic                  proc_full,
    output logic                  block_fin,
    output logic [PEND_W-1:0]     blocks_pending,
    output logic                  ovf_err
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W  = $clog2(MAX_BURST);
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

    proc_state_t        r_state;
    proc_state_t        w_state_next;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic               r_out_en;
    logic               r_proc_full;
    logic               r_block_fin;
    logic [PEND_W-1:0]  r_pending;
    logic               r_ovf;

    logic               w_awready;
    logic               w_wready;
    logic               w_wr_en;
    logic               w_beat_clr;
    logic               w_beat_inc;
    logic               w_pend_inc;
    logic               w_pend_dec;
    logic               w_set_ovf;
    logic               w_beat_at_max;
    logic               w_m_valid;
    logic               w_m_hs;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;

    assign w_beat_at_max = (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
    assign w_wr_entry    = {bus.s_wlast | w_beat_at_max, bus.s_wdata};

    proc_block_buffer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wr_en        (w_wr_en),
        .i_wr_data      (w_wr_entry),
        .i_rd_en        (w_m_hs),
        .o_rd_data      (w_rd_entry),
        .o_count        (w_count),
        .o_count_next_c (w_count_next)
    );

    // Burst intake FSM: next state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_wr_en      = 1'b0;
        w_beat_clr   = 1'b0;
        w_beat_inc   = 1'b0;
        w_pend_inc   = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            P_IDLE: begin
                w_awready = r_out_en && !(is_block(bus.s_awuser) && r_proc_full);
                if (bus.s_awvalid && w_awready) begin
                    w_beat_clr   = 1'b1;
                    w_state_next = is_block(bus.s_awuser) ? P_FILL : P_DROP;
                end
            end
            P_FILL: begin
                w_wready = (w_count < CNT_W'(DEPTH));
                if (bus.s_wvalid && w_wready) begin
                    w_wr_en    = 1'b1;
                    w_beat_inc = 1'b1;
                    if (bus.s_wlast) begin
                        w_pend_inc   = 1'b1;
                        w_state_next = P_IDLE;
                    end else if (w_beat_at_max) begin
                        // Oversized burst: close the stored block, swallow the tail
                        w_pend_inc   = 1'b1;
                        w_set_ovf    = 1'b1;
                        w_state_next = P_DROP;
                    end
                end
            end
            P_DROP: begin
                w_wready = 1'b1;
                if (bus.s_wvalid && bus.s_wlast) begin
                    w_state_next = P_IDLE;
                end
            end
            default: begin
                w_state_next = P_IDLE;
            end
        endcase
    end

    assign w_m_valid  = (w_count != '0);
    assign w_m_hs     = w_m_valid && bus.m_ready;
    assign w_pend_dec = w_m_hs && w_rd_entry[DATA_WIDTH];

    // r_out_en holds the address channel closed until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= P_IDLE;
            r_beat_cnt  <= '0;
            r_out_en    <= 1'b0;
            r_proc_full <= 1'b0;
            r_block_fin <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_en    <= 1'b1;
            r_proc_full <= (w_count_next > CNT_W'(DEPTH - MAX_BURST));
            r_block_fin <= w_pend_dec;
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_beat_clr) begin
                r_beat_cnt <= '0;
            end else if (w_beat_inc) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    // Saturating count of complete blocks not yet drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_pend_inc && !w_pend_dec && (r_pending != {PEND_W{1'b1}})) begin
            r_pending <= r_pending + PEND_W'(1);
        end else if (w_pend_dec && !w_pend_inc && (r_pending != '0)) begin
            r_pending <= r_pending - PEND_W'(1);
        end
    end

    assign bus.s_awready  = w_awready;
    assign bus.s_wready   = w_wready;
    assign bus.m_valid    = w_m_valid;
    assign bus.m_data     = w_rd_entry[DATA_WIDTH-1:0];
    assign bus.m_last     = w_rd_entry[DATA_WIDTH];
    assign proc_full      = r_proc_full;
    assign block_fin      = r_block_fin;
    assign blocks_pending = r_pending;
    assign ovf_err        = r_ovf;

endmodule

// File: tb/tb_proc_block_buffer.sv
// Directed bench for proc_block_buffer: fill/drain framing, backpressure, overflow, reset.
// Inputs change and outputs are sampled 1-2 time units after the rising clock edge.
module tb_proc_block_buffer;
    import proc_block_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       proc_full;
    logic       block_fin;
    logic [3:0] blocks_pending;
    logic       ovf_err;
    int         checks = 0;
    int         errors = 0;

    proc_block_buffer_if #(.DATA_WIDTH(32)) u_if ();

    proc_block_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .MAX_BURST  (8),
        .PEND_W     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (u_if),
        .proc_full      (proc_full),
        .block_fin      (block_fin),
        .blocks_pending (blocks_pending),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [PAWUSER_WIDTH-1:0] user, input string tag);
        u_if.s_awvalid = 1'b1;
        u_if.s_awuser  = user;
        #1;
        chk({tag, " awready"}, 32'(u_if.s_awready), 32'd1);
        tick();
        u_if.s_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic last, input string tag);
        u_if.s_wvalid = 1'b1;
        u_if.s_wdata  = data;
        u_if.s_wlast  = last;
        #1;
        chk({tag, " wready"}, 32'(u_if.s_wready), 32'd1);
        tick();
        u_if.s_wvalid = 1'b0;
        u_if.s_wlast  = 1'b0;
    endtask

    task automatic do_r(input logic [31:0] data, input logic last, input string tag);
        u_if.m_ready = 1'b1;
        #1;
        chk({tag, " m_valid"}, 32'(u_if.m_valid), 32'd1);
        chk({tag, " m_data"},  u_if.m_data, data);
        chk({tag, " m_last"},  32'(u_if.m_last), 32'(last));
        tick();
        u_if.m_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " awready"},  32'(u_if.s_awready), 32'd0);
        chk({tag, " wready"},   32'(u_if.s_wready), 32'd0);
        chk({tag, " m_valid"},  32'(u_if.m_valid), 32'd0);
        chk({tag, " proc_full"}, 32'(proc_full), 32'd0);
        chk({tag, " block_fin"}, 32'(block_fin), 32'd0);
        chk({tag, " pending"},  32'(blocks_pending), 32'd0);
        chk({tag, " ovf_err"},  32'(ovf_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.s_awvalid = 1'b0;
        u_if.s_awuser  = REGULAR;
        u_if.s_wvalid  = 1'b0;
        u_if.s_wdata   = '0;
        u_if.s_wlast   = 1'b0;
        u_if.m_ready   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("RST");
        rst_n = 1'b1;
        tick();

        // T1: 4-beat block, held then drained in order
        do_aw(BLOCK, "T1");
        for (int i = 0; i < 4; i++) do_w(32'hA0 + i, i == 3, "T1 w");
        chk("T1 pending", 32'(blocks_pending), 32'd1);
        chk("T1 proc_full", 32'(proc_full), 32'd0);
        chk("T1 m_valid held", 32'(u_if.m_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_r(32'hA0 + i, i == 3, "T1 r");
            chk("T1 block_fin", 32'(block_fin), 32'(i == 3));
        end
        tick();
        chk("T1 block_fin pulse end", 32'(block_fin), 32'd0);
        chk("T1 empty", 32'(u_if.m_valid), 32'd0);
        chk("T1 pending end", 32'(blocks_pending), 32'd0);

        // T2: two 5-beat blocks, proc_full and AW backpressure
        do_aw(BLOCK, "T2a");
        for (int i = 0; i < 5; i++) do_w(32'hB0 + i, i == 4, "T2 wb");
        chk("T2 proc_full at 5", 32'(proc_full), 32'd0);
        do_aw(BLOCK, "T2b");
        for (int i = 0; i < 5; i++) begin
            do_w(32'hC0 + i, i == 4, "T2 wc");
            chk("T2 proc_full", 32'(proc_full), 32'(i >= 3));
        end
        chk("T2 pending", 32'(blocks_pending), 32'd2);
        u_if.s_awvalid = 1'b1;
        u_if.s_awuser  = BLOCK;
        #1;
        chk("T2 aw held", 32'(u_if.s_awready), 32'd0);
        tick();
        chk("T2 aw still held", 32'(u_if.s_awready), 32'd0);
        do_r(32'hB0, 1'b0, "T2 r");
        chk("T2 aw held at 9", 32'(u_if.s_awready), 32'd0);
        do_r(32'hB1, 1'b0, "T2 r");
        chk("T2 proc_full at 8", 32'(proc_full), 32'd0);
        chk("T2 aw open at 8", 32'(u_if.s_awready), 32'd1);
        tick();
        u_if.s_awvalid = 1'b0;
        do_w(32'hD0, 1'b1, "T2 wd");
        for (int i = 2; i < 5; i++) do_r(32'hB0 + i, i == 4, "T2 rb");
        chk("T2 block_fin b", 32'(block_fin), 32'd1);
        for (int i = 0; i < 5; i++) do_r(32'hC0 + i, i == 4, "T2 rc");
        chk("T2 block_fin c", 32'(block_fin), 32'd1);
        do_r(32'hD0, 1'b1, "T2 rd");
        chk("T2 pending end", 32'(blocks_pending), 32'd0);
        chk("T2 empty", 32'(u_if.m_valid), 32'd0);

        // T3: REGULAR burst consumed and discarded
        do_aw(REGULAR, "T3");
        for (int i = 0; i < 3; i++) begin
            do_w(32'h30 + i, i == 2, "T3 w");
            chk("T3 m_valid", 32'(u_if.m_valid), 32'd0);
            chk("T3 block_fin", 32'(block_fin), 32'd0);
        end
        chk("T3 pending", 32'(blocks_pending), 32'd0);

        // T4: 10-beat block truncated at 8 beats
        do_aw(BLOCK, "T4");
        for (int i = 0; i < 10; i++) begin
            do_w(32'hE0 + i, i == 9, "T4 w");
            if (i == 7) begin
                chk("T4 ovf_err", 32'(ovf_err), 32'd1);
                chk("T4 pending", 32'(blocks_pending), 32'd1);
            end
        end
        do_aw(BLOCK, "T4 next");
        do_w(32'hF0, 1'b1, "T4 wf");
        for (int i = 0; i < 8; i++) do_r(32'hE0 + i, i == 7, "T4 r");
        chk("T4 block_fin", 32'(block_fin), 32'd1);
        do_r(32'hF0, 1'b1, "T4 rf");
        chk("T4 ovf sticky", 32'(ovf_err), 32'd1);
        chk("T4 empty", 32'(u_if.m_valid), 32'd0);

        // T5: drain of A's last beat coincides with B's wlast write
        do_aw(BLOCK, "T5a");
        do_w(32'h50, 1'b1, "T5 wa");
        do_aw(BLOCK, "T5b");
        u_if.s_wvalid = 1'b1;
        u_if.s_wdata  = 32'h51;
        u_if.s_wlast  = 1'b1;
        u_if.m_ready  = 1'b1;
        #1;
        chk("T5 m_data a", u_if.m_data, 32'h50);
        chk("T5 m_last a", 32'(u_if.m_last), 32'd1);
        chk("T5 wready", 32'(u_if.s_wready), 32'd1);
        tick();
        u_if.s_wvalid = 1'b0;
        u_if.s_wlast  = 1'b0;
        u_if.m_ready  = 1'b0;
        chk("T5 pending", 32'(blocks_pending), 32'd1);
        chk("T5 block_fin", 32'(block_fin), 32'd1);
        chk("T5 m_data b", u_if.m_data, 32'h51);
        tick();
        chk("T5 block_fin once", 32'(block_fin), 32'd0);
        do_r(32'h51, 1'b1, "T5 rb");
        chk("T5 block_fin b", 32'(block_fin), 32'd1);
        chk("T5 pending end", 32'(blocks_pending), 32'd0);

        // T6: reset mid-fill with three beats stored
        do_aw(BLOCK, "T6");
        for (int i = 0; i < 3; i++) do_w(32'h60 + i, 1'b0, "T6 w");
        chk("T6 m_valid pre", 32'(u_if.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("T6 RST");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        do_aw(BLOCK, "T6 new");
        do_w(32'h70, 1'b0, "T6 wk");
        do_w(32'h71, 1'b1, "T6 wk");
        chk("T6 pending", 32'(blocks_pending), 32'd1);
        do_r(32'h70, 1'b0, "T6 r");
        do_r(32'h71, 1'b1, "T6 r");
        chk("T6 block_fin", 32'(block_fin), 32'd1);
        chk("T6 ovf clear", 32'(ovf_err), 32'd0);
        tick();
        chk("T6 block_fin end", 32'(block_fin), 32'd0);
        chk("T6 empty", 32'(u_if.m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
